// File: rtl/bcd2bin_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest binary width able to hold 10^digits - 1.
  function automatic int unsigned min_bin_w(input int unsigned digits);
    longint unsigned p;
    int unsigned     w;
    p = 1;
    w = 0;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    while ((64'd1 << w) < p) w++;
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Operand/result handshake bundle between digit capture and register-file write path.
interface bcd2bin_seq_if
  import bcd2bin_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [NIB_W*DIGITS-1:0]   bcd_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [BIN_W-1:0]          bin_out;
  logic                      err;
  logic                      busy;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, err, busy
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, err, busy
  );

endinterface

// File: rtl/bcd2bin_seq_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that is >= 8.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  output logic [NIB_W-1:0] y
);

  always_comb y = x[NIB_W-1] ? x - NIB_W'(3) : x;

endmodule

// File: rtl/bcd2bin_seq.sv
// Multi-cycle BCD-to-binary converter: one reverse double-dabble iteration per clock.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_seq_if.slave  bus
);

  localparam int unsigned BCD_W = NIB_W * DIGITS;
  localparam int unsigned SH_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < 1 || DIGITS > 9 || BIN_W < min_bin_w(DIGITS)) begin : g_bad_cfg
    $error("bcd2bin_seq: BIN_W=%0d too narrow for DIGITS=%0d", BIN_W, DIGITS);
  end

  state_t           state_q, state_d;
  logic [SH_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             err_q, err_d;

  logic [SH_W-1:0]  shifted;
  logic [SH_W-1:0]  shreg_adj;
  logic [NIB_W-1:0] adj_nib [DIGITS];
  logic [DIGITS-1:0] nib_bad;
  logic             any_bad;
  logic             accept;

  assign shifted = shreg_q >> 1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_adj u_adj (
      .x (shifted[BIN_W+NIB_W*k +: NIB_W]),
      .y (adj_nib[k])
    );
    assign nib_bad[k] = bus.bcd_in[NIB_W*k +: NIB_W] > NIB_W'(9);
  end

  assign any_bad = |nib_bad;

  always_comb begin
    shreg_adj = shifted;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      shreg_adj[BIN_W+NIB_W*k +: NIB_W] = adj_nib[k];
    end
  end

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.bin_out   = bin_q;
  assign bus.err       = err_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        // IDLE and DONE share the accept path so a handshake in DONE reloads with no bubble.
        if (accept) begin
          if (any_bad) begin
            state_d = DONE;
            err_d   = 1'b1;
            bin_d   = '0;
          end else begin
            state_d = SHIFT;
            shreg_d = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = CNT_W'(BIN_W);
            err_d   = 1'b0;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shreg_d = shreg_adj;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          bin_d   = shreg_adj[BIN_W-1:0];
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Parametrised, multi-cycle BCD-to-binary converter using reverse double-dabble: shift right one bit, then subtract 3 from every BCD nibble that is >= 8.
- Performs one iteration per clock, so a wide conversion costs one small adder per digit instead of a fully unrolled combinational chain.
- Adds valid/ready handshakes on input and output, plus invalid-digit detection.
- Sits between the keypad/console digit capture and the register-file write path of the processor.

Parameters:
- DIGITS, 4, number of BCD digits accepted (1..9).
- BIN_W, 14, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1; an elaboration-time check fails otherwise.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, a BCD operand is presented.
- in_ready, output, 1, the block will accept the operand on this edge.
- bcd_in, input, 4*DIGITS, packed digits; digit 0 (ones) is bits [3:0], and the most significant digit is at the top.
- out_valid, output, 1, the result is available.
- out_ready, input, 1, the consumer takes the result.
- bin_out, output, BIN_W, the binary value.
- err, output, 1, qualified by out_valid; at least one nibble of the accepted operand was > 9.
- busy, output, 1, high while in state SHIFT.

Behaviour:
- Reset: state = IDLE; in_ready = 1; out_valid = 0; bin_out = 0; err = 0; busy = 0; shift register and counter cleared.
  - Reset asserted mid-conversion or while a result is held discards the operation. No output handshake occurs.
- State machine (IDLE, SHIFT, DONE):
  - IDLE: in_ready = 1. On in_valid:
    - Any nibble > 9: go to DONE with err = 1 and bin_out = 0. Latency is 1 edge.
    - Otherwise: load shreg = {bcd_in, BIN_W'b0} (width 4*DIGITS + BIN_W), set cnt = BIN_W, go to SHIFT.
  - SHIFT: on each edge, shreg = shreg >> 1; then, for every digit field at bits [BIN_W+4k+3 : BIN_W+4k], if the field is >= 8, subtract 3. All digits are adjusted in parallel from the shifted value. Decrement cnt. When cnt reaches 1 on that edge, go to DONE, set bin_out = shreg_next[BIN_W-1:0], err = 0, out_valid = 1.
  - DONE: out_valid = 1; bin_out and err are held stable until out_valid & out_ready.
    - On handshake without a new operand: go to IDLE.
- Latency: out_valid rises BIN_W+1 edges after the accepting edge counts as edge 1, i.e. 15 edges for the defaults. Throughput is one operation per BIN_W+1 cycles.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
  - A simultaneous output handshake and in_valid in DONE accepts the new operand on the same edge (no bubble). That edge loads the operand and clears out_valid, or sets err/out_valid again on the 1-cycle error path.
- in_valid is ignored while in SHIFT; bcd_in is sampled only on the accepting edge.
- Width rules:
  - Nibble adjust is a 4-bit subtract; it cannot underflow because the field is >= 8.
  - The top BCD bits shifted out are zero after BIN_W iterations for any legal operand.
  - No saturation is needed because of the BIN_W constraint.
- busy = (state == SHIFT).

Decomposition:
- Package bcd2bin_pkg contains:
  - The state enum {IDLE, SHIFT, DONE}.
  - Function min_bin_w(digits), returning ceil(log2(10^digits)), used by the elaboration check.
  - Constant NIB_W = 4.
- Sub-module bcd_digit_adj: 4-bit input, 4-bit output, combinational (x >= 8 ? x - 3 : x). Instantiated DIGITS times with a generate loop.
- Validity check: a generate-OR of (nibble > 9) across all digits.

Test Plan:
1. bcd_in = 16'h9999, out_ready = 1 → out_valid rises on edge 15 after acceptance; bin_out = 14'h270F (9999); err = 0; busy high for exactly 14 cycles.
2. bcd_in = 16'h0000, then 16'h0001, then 16'h1024 → bin_out = 0, 1, 1024 respectively, each with err = 0.
3. bcd_in = 16'h12A4 → out_valid after 1 edge, err = 1, bin_out = 0, busy never asserts.
4. Backpressure: convert 16'h4321 with out_ready = 0 for 10 cycles → bin_out = 4321 held stable, in_ready = 0. Raise out_ready together with in_valid and 16'h0500 → back-to-back accept on that edge; next result is 500.
5. Reset mid-conversion: assert rst on the 7th SHIFT cycle of 16'h8888 → next edge gives state IDLE, out_valid = 0, bin_out = 0. A following conversion of 16'h0042 yields 42 with no residue from the aborted operation.
6. Parameter sweep DIGITS = 2, BIN_W = 7: bcd_in = 8'h99 → 99 after 8 edges. DIGITS = 6, BIN_W = 20: 24'h999999 → 999999.
